// File: rtl/ppu_pkg.sv
// Shared PPU types: posit word, operation codes and the
// issue-controller request/result bundles.
package ppu_pkg;

    localparam int PPU_N                = 16;
    localparam int PPU_TAG_W            = 4;
    localparam int PPU_ISSUE_FIFO_DEPTH = 4;

    typedef logic [PPU_N-1:0] posit_t;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_DIV,
        OP_FMA
    } operation_e;

    typedef struct packed {
        operation_e             op;
        posit_t                 p1;
        posit_t                 p2;
        posit_t                 p3;
        logic [PPU_TAG_W-1:0]   tag;
    } ppu_req_t;

    typedef struct packed {
        posit_t                 pout;
        logic [PPU_TAG_W-1:0]   tag;
        logic                   src;
    } ppu_res_t;

endpackage

// File: rtl/ppu_result_fifo.sv
// In-order result FIFO; head entry drives the outputs directly.
// Ports: push_i/data_i write, pop_i/valid_o/data_o read, count_o occupancy.
module ppu_result_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = PPU_ISSUE_FIFO_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  ppu_res_t                 data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output ppu_res_t                 data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    ppu_res_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_pop;

    assign do_pop  = pop_i && (count != '0);
    assign valid_o = (count != '0);
    assign data_o  = mem[rd_ptr];
    assign count_o = count;

    // Push and pop at full is fine: the head is read before the
    // slot it occupies is overwritten at the same edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push_i}
                           - {{AW{1'b0}}, do_pop};
        end
    end

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_i)
        !(push_i && (count == FULL) && !pop_i)
    );

endmodule

// File: rtl/ppu_issue_ctrl.sv
// Round-robin issue of two requesters into ppu_core_ops with credit-based
// result buffering. Ports: req0/req1 valid-ready, core_* issue, res_* output.
module ppu_issue_ctrl
    import ppu_pkg::*;
#(
    parameter int N          = 16,
    parameter int LATENCY    = 0,
    parameter int FIFO_DEPTH = PPU_ISSUE_FIFO_DEPTH,
    parameter int TAG_W      = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  operation_e         req0_op_i,
    input  posit_t             req0_p1_i,
    input  posit_t             req0_p2_i,
    input  posit_t             req0_p3_i,
    input  logic [TAG_W-1:0]   req0_tag_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  operation_e         req1_op_i,
    input  posit_t             req1_p1_i,
    input  posit_t             req1_p2_i,
    input  posit_t             req1_p3_i,
    input  logic [TAG_W-1:0]   req1_tag_i,
    output logic               core_valid_o,
    output operation_e         core_op_o,
    output posit_t             core_p1_o,
    output posit_t             core_p2_o,
    output posit_t             core_p3_o,
    output logic               core_stall_o,
    input  posit_t             core_pout_i,
    output logic               res_valid_o,
    input  logic               res_ready_i,
    output posit_t             res_pout_o,
    output logic [TAG_W-1:0]   res_tag_o,
    output logic               res_src_o
);

    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1) + 1;
    localparam int FW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic             valid;
        logic             src;
        logic [TAG_W-1:0] tag;
    } trk_t;

    logic          prio;
    logic          gnt0;
    logic          gnt1;
    logic          issue;
    logic          pop;
    logic          credit_ok;
    logic [CW-1:0] inflight;
    logic [CW-1:0] occ;
    logic [FW-1:0] count;
    ppu_req_t      sel;
    trk_t          issue_ent;
    trk_t          emerge;
    ppu_res_t      push_data;
    ppu_res_t      head;

    a_param: assert property (
        @(posedge clk_i) (N == PPU_N) && (TAG_W == PPU_TAG_W)
    );

    assign pop = res_valid_o & res_ready_i;

    // Everything in flight or buffered, minus what leaves this cycle,
    // must fit in the FIFO so a completing result always has a slot.
    assign occ       = inflight + CW'(count) - CW'(pop);
    assign credit_ok = occ < CW'(FIFO_DEPTH);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_i && credit_ok) begin
            if (req0_valid_i && req1_valid_i) begin
                gnt0 = !prio;
                gnt1 = prio;
            end else begin
                gnt0 = req0_valid_i;
                gnt1 = req1_valid_i;
            end
        end
    end

    assign issue        = gnt0 | gnt1;
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    // prio names the requester that wins the next tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prio <= 1'b0;
        end else if (issue) begin
            prio <= gnt0;
        end
    end

    always_comb begin
        sel = '{
            op:  req0_op_i,
            p1:  req0_p1_i,
            p2:  req0_p2_i,
            p3:  req0_p3_i,
            tag: PPU_TAG_W'(req0_tag_i)
        };
        if (gnt1) begin
            sel = '{
                op:  req1_op_i,
                p1:  req1_p1_i,
                p2:  req1_p2_i,
                p3:  req1_p3_i,
                tag: PPU_TAG_W'(req1_tag_i)
            };
        end
    end

    assign core_valid_o = issue;
    assign core_op_o    = sel.op;
    assign core_p1_o    = sel.p1;
    assign core_p2_o    = sel.p2;
    assign core_p3_o    = sel.p3;
    assign core_stall_o = 1'b0;

    assign issue_ent = '{
        valid: issue,
        src:   gnt1,
        tag:   TAG_W'(sel.tag)
    };

    if (LATENCY == 0) begin : g_lat0
        assign inflight = '0;
        assign emerge   = issue_ent;
    end else begin : g_pipe
        trk_t trk [LATENCY];

        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                for (int i = 0; i < LATENCY; i++) begin
                    trk[i] <= '0;
                end
            end else begin
                trk[0] <= issue_ent;
                for (int i = 1; i < LATENCY; i++) begin
                    trk[i] <= trk[i-1];
                end
            end
        end

        always_comb begin
            inflight = '0;
            for (int i = 0; i < LATENCY; i++) begin
                inflight = inflight + CW'(trk[i].valid);
            end
        end

        assign emerge = trk[LATENCY-1];
    end

    assign push_data = '{
        pout: core_pout_i,
        tag:  PPU_TAG_W'(emerge.tag),
        src:  emerge.src
    };

    ppu_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (emerge.valid),
        .data_i  (push_data),
        .pop_i   (pop),
        .valid_o (res_valid_o),
        .data_o  (head),
        .count_o (count)
    );

    assign res_pout_o = head.pout;
    assign res_tag_o  = TAG_W'(head.tag);
    assign res_src_o  = head.src;

endmodule

// File: tb/tb_ppu_issue_ctrl.sv
// Scoreboard bench for ppu_issue_ctrl: one instance with a 2-cycle core,
// one with a zero-latency core, both with a 4-entry result FIFO.
module tb_ppu_issue_ctrl;
    import ppu_pkg::*;

    localparam int FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input int inst, input string name,
                       input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL inst%0d %s: got %0d expected %0d",
                     inst, name, act, exp);
        end
    endtask

    function automatic posit_t core_fn(input operation_e op,
                                       input posit_t a,
                                       input posit_t b,
                                       input posit_t c);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_MUL:  return a * b;
            OP_DIV:  return (b == '0) ? '1 : a / b;
            default: return a * b + c;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 2 : 0;

        typedef struct {
            posit_t     pout;
            logic [3:0] tag;
            logic       src;
            int         avail;
        } exp_t;

        logic       rst;
        logic       fin = 1'b0;
        logic       v   [2];
        operation_e op  [2];
        posit_t     p1  [2];
        posit_t     p2  [2];
        posit_t     p3  [2];
        logic [3:0] tg  [2];
        logic       rdy0, rdy1;
        logic       core_valid, core_stall;
        operation_e core_op;
        posit_t     core_p1, core_p2, core_p3, core_pout;
        logic       res_valid, res_ready, res_src;
        posit_t     res_pout;
        logic [3:0] res_tag;

        exp_t q [$];
        int   cyc = 0;
        logic gnt_m [2];
        logic prio_m;
        int   tagc [2];

        ppu_issue_ctrl #(
            .N          (16),
            .LATENCY    (LAT),
            .FIFO_DEPTH (FD),
            .TAG_W      (4)
        ) dut (
            .clk_i        (clk),
            .rst_i        (rst),
            .req0_valid_i (v[0]),
            .req0_ready_o (rdy0),
            .req0_op_i    (op[0]),
            .req0_p1_i    (p1[0]),
            .req0_p2_i    (p2[0]),
            .req0_p3_i    (p3[0]),
            .req0_tag_i   (tg[0]),
            .req1_valid_i (v[1]),
            .req1_ready_o (rdy1),
            .req1_op_i    (op[1]),
            .req1_p1_i    (p1[1]),
            .req1_p2_i    (p2[1]),
            .req1_p3_i    (p3[1]),
            .req1_tag_i   (tg[1]),
            .core_valid_o (core_valid),
            .core_op_o    (core_op),
            .core_p1_o    (core_p1),
            .core_p2_o    (core_p2),
            .core_p3_o    (core_p3),
            .core_stall_o (core_stall),
            .core_pout_i  (core_pout),
            .res_valid_o  (res_valid),
            .res_ready_i  (res_ready),
            .res_pout_o   (res_pout),
            .res_tag_o    (res_tag),
            .res_src_o    (res_src)
        );

        // Core stand-in: never reset, drives junk when nothing is valid.
        posit_t pipe  [9];
        logic   vpipe [9];
        posit_t junk;

        always @(posedge clk) begin
            junk     <= posit_t'($urandom);
            pipe[0]  <= core_fn(core_op, core_p1, core_p2, core_p3);
            vpipe[0] <= core_valid;
            for (int i = 1; i < 9; i++) begin
                pipe[i]  <= pipe[i-1];
                vpipe[i] <= vpipe[i-1];
            end
        end

        if (LAT == 0) begin : g_c0
            assign core_pout = core_valid
                ? core_fn(core_op, core_p1, core_p2, core_p3) : junk;
        end else begin : g_cn
            assign core_pout = vpipe[LAT-1] ? pipe[LAT-1] : junk;
        end

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: compares the result port against the queue head.
        always @(negedge clk) begin
            if (rst) begin
                if (q.size() > 0 && q[0].avail <= cyc) begin
                    chk(g, "res_valid", res_valid, 1);
                    chk(g, "res_tag", res_tag, q[0].tag);
                    chk(g, "res_src", res_src, q[0].src);
                    chk(g, "res_pout", res_pout, q[0].pout);
                    if (res_ready) void'(q.pop_front());
                end else begin
                    chk(g, "res_valid", res_valid, 0);
                end
            end
        end

        // Reference: arbitration and credit from outstanding count.
        always @(negedge clk) begin : model
            logic w0, w1, credit;
            int   k;
            #1;
            if (!rst) begin
                q.delete();
                prio_m   = 1'b0;
                gnt_m[0] = 1'b0;
                gnt_m[1] = 1'b0;
                chk(g, "rst_rdy0", rdy0, 0);
                chk(g, "rst_rdy1", rdy1, 0);
                chk(g, "rst_core_valid", core_valid, 0);
                chk(g, "rst_res_valid", res_valid, 0);
                chk(g, "rst_res_tag", res_tag, 0);
                chk(g, "rst_res_src", res_src, 0);
                chk(g, "rst_res_pout", res_pout, 0);
            end else begin
                credit = q.size() < FD;
                w0 = 1'b0;
                w1 = 1'b0;
                if (credit) begin
                    if (v[0] && v[1]) begin
                        w0 = !prio_m;
                        w1 = prio_m;
                    end else begin
                        w0 = v[0];
                        w1 = v[1];
                    end
                end
                chk(g, "ready0", rdy0, w0);
                chk(g, "ready1", rdy1, w1);
                chk(g, "core_valid", core_valid, w0 | w1);
                chk(g, "core_stall", core_stall, 0);
                if (w0 || w1) begin
                    k = w1 ? 1 : 0;
                    chk(g, "core_op", core_op, op[k]);
                    chk(g, "core_p1", core_p1, p1[k]);
                    chk(g, "core_p2", core_p2, p2[k]);
                    chk(g, "core_p3", core_p3, p3[k]);
                    q.push_back('{core_fn(op[k], p1[k], p2[k], p3[k]),
                                  tg[k], (k == 1), cyc + LAT + 1});
                    prio_m = w0;
                end
                gnt_m[0] = w0;
                gnt_m[1] = w1;
            end
        end

        task automatic drive(input int pv0, input int pv1, input int pr);
            int pv;
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (!v[k] || gnt_m[k]) begin
                    pv    = (k == 0) ? pv0 : pv1;
                    v[k]  = int'($urandom_range(0, 99)) < pv;
                    op[k] = operation_e'($urandom_range(0, 4));
                    p1[k] = posit_t'($urandom);
                    p2[k] = posit_t'($urandom);
                    p3[k] = posit_t'($urandom);
                    tg[k] = 4'(tagc[k]);
                    if (v[k]) tagc[k]++;
                end
            end
            res_ready = int'($urandom_range(0, 99)) < pr;
        endtask

        initial begin : drv
            int n;
            rst       = 1'b0;
            res_ready = 1'b1;
            tagc      = '{0, 0};
            v[0]  = 1'b1;
            op[0] = OP_ADD;
            p1[0] = posit_t'($urandom);
            p2[0] = posit_t'($urandom);
            p3[0] = '0;
            tg[0] = 4'd3;
            v[1]  = 1'b0;
            op[1] = OP_ADD;
            p1[1] = '0;
            p2[1] = '0;
            p3[1] = '0;
            tg[1] = 4'd0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            repeat (8) drive(0, 0, 100);

            tagc = '{0, 0};
            repeat (12) drive(100, 100, 100);
            repeat (8) drive(0, 0, 100);

            n = 0;
            repeat (12) begin
                drive(100, 0, 0);
                @(negedge clk);
                if (rdy0) n++;
            end
            chk(g, "bp_accepts", n, FD);
            drive(100, 0, 100);
            @(negedge clk);
            chk(g, "bp_one_more", rdy0, 1);
            n = 0;
            repeat (4) begin
                drive(100, 0, 0);
                @(negedge clk);
                if (rdy0) n++;
            end
            chk(g, "bp_hold", n, 0);

            repeat (20) drive(100, 100, 100);
            repeat (300) drive(70, 70, 60);

            repeat (5) drive(100, 100, 0);
            @(posedge clk);
            #1;
            rst  = 1'b0;
            v[0] = 1'b0;
            v[1] = 1'b0;
            #1;
            chk(g, "rst_now_res_valid", res_valid, 0);
            chk(g, "rst_now_core_valid", core_valid, 0);
            repeat (2) @(posedge clk);
            #1 rst = 1'b1;
            repeat (10) drive(0, 0, 100);

            tagc = '{0, 0};
            repeat (16) drive(100, 0, 100);
            n = 0;
            while ((q.size() > 0 || v[0] || v[1]) && n < 100) begin
                drive(0, 0, 100);
                n++;
            end
            chk(g, "drain_left", q.size(), 0);
            fin = 1'b1;
        end
    end

    initial begin
        for (int i = 0; i < 20000; i++) begin
            if (g_inst[0].fin && g_inst[1].fin) break;
            @(posedge clk);
        end
        checks++;
        if (!(g_inst[0].fin && g_inst[1].fin)) begin
            failures++;
            $display("FAIL timeout: got unfinished expected finished");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
